// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle unsigned multiply/divide engine that owns the HI/LO registers
// for the execute stage. A start launches a shift-add multiply or a restoring
// divide that retires one bit per cycle. The result is committed to HI/LO in a
// single DONE cycle. While an op is in flight, any HI/LO access or a second
// start from execute is held off through stall.
//
// Ports
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    execute holds MULT/DIV this cycle
//   is_div   1 = divide, 0 = multiply (sampled with start)
//   op_a     multiplicand / dividend; also the MTHI/MTLO source
//   op_b     multiplier / divisor
//   rd_req   execute holds MFHI/MFLO
//   wr_hi    MTHI: load HI from op_a (IDLE only)
//   wr_lo    MTLO: load LO from op_a (IDLE only)
//   flush    squash the in-flight op
//   busy     op in flight (MUL or DIV state)
//   done     one-cycle pulse in the commit cycle
//   stall    hold fetch/decode/execute this cycle
//   hi, lo   HI and LO registers

module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6      // 2**CNT_W must exceed WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_req,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] count;
    // Multiply: operand = multiplicand, {work_hi, work_lo} = partial product
    //           with the unconsumed multiplier bits in the low half.
    // Divide:   operand = divisor, work_hi = partial remainder,
    //           work_lo = dividend bits shifting out / quotient bits shifting in.
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic             load;
    logic             iterate;
    logic             commit;
    logic             last_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // One iteration of either algorithm.
    // Multiply: add the multiplicand when the low multiplier bit is set, then
    //           shift the whole product right. The carry enters the top bit.
    // Divide:   shift the next dividend bit into the remainder and subtract
    //           when it fits. The quotient bit enters from the right.
    //           A zero divisor always "fits", which yields an all-ones
    //           quotient and leaves the dividend as the remainder.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, operand});
        // When div_fits holds, the true difference is below the divisor,
        // so the modular WIDTH-bit subtraction is exact.
        div_diff  = div_shift[WIDTH-1:0] - operand;
        if (state == DIV) begin
            step_hi = div_fits ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_fits};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides everything, including a start in IDLE and the commit in DONE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        iterate    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && start) begin
                    load       = 1'b1;
                    state_next = is_div ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    iterate = 1'b1;
                    if (last_iter) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                commit     = !flush;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy  = (state == MUL) || (state == DIV);
    assign done  = (state == DONE) && !flush;
    assign stall = busy & (rd_req | wr_hi | wr_lo | start);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            operand <= '0;
            work_hi <= '0;
            work_lo <= '0;
        end else if (load) begin
            // The product is commutative, so both algorithms can take op_a
            // into the low half and keep op_b as the fixed operand.
            count   <= '0;
            operand <= op_b;
            work_hi <= '0;
            work_lo <= op_a;
        end else if (iterate) begin
            count   <= count + CNT_W'(1);
            work_hi <= step_hi;
            work_lo <= step_lo;
        end
    end

    // MTHI/MTLO are accepted only in IDLE, and only when no start or flush
    // is present in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= work_hi;
            lo <= work_lo;
        end else if ((state == IDLE) && !flush && !start) begin
            if (wr_hi) begin
                hi <= op_a;
            end
            if (wr_lo) begin
                lo <= op_a;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Directed and randomized test of muldiv_sequencer. The expected HI/LO values
// come from plain 64-bit arithmetic. Inputs are driven 1 time unit after the
// rising edge, and outputs are checked 1 time unit later.

module tb_muldiv_sequencer;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             is_div = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             rd_req = 1'b0;
    logic             wr_hi = 1'b0;
    logic             wr_lo = 1'b0;
    logic             flush = 1'b0;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_hi = '0;
    logic [WIDTH-1:0] exp_lo = '0;

    muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .is_div  (is_div),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_req  (rd_req),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clock = ~clock;

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic div);
        logic [63:0] r;
        if (!div) begin
            r = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic d, input logic [31:0] a, input logic [31:0] b,
                                 input logic rq, input logic wh, input logic wl, input logic fl);
        start  = s;
        is_div = d;
        op_a   = a;
        op_b   = b;
        rd_req = rq;
        wr_hi  = wh;
        wr_lo  = wl;
        flush  = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Runs one MULT/DIV.
    // rd_from:    cycle from which MFHI/MFLO is held (0 = never).
    // busy_start: re-present start in cycles 5..6 while the op is in flight.
    // flush_at:   cycle in which flush is pulsed (0 = never; WIDTH+1 is the DONE cycle).
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic div,
                         input int rd_from, input bit busy_start, input int flush_at);
        logic [63:0] res;
        logic        req;
        logic        extra;
        res = model(a, b, div);
        applyStimulus(1'b1, div, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("issue_busy", busy, 0);
        checkOutput("issue_stall", stall, 0);
        step();
        for (int cyc = 1; cyc <= WIDTH + 1; cyc++) begin
            req   = (rd_from != 0) && (cyc >= rd_from);
            extra = busy_start && (cyc >= 5) && (cyc <= 6);
            if (extra) begin
                applyStimulus(1'b1, ~div, ~a, b + 32'd1, req, 1'b0, 1'b0, flush_at == cyc);
            end else begin
                applyStimulus(1'b0, div, a, b, req, 1'b0, 1'b0, flush_at == cyc);
            end
            #1;
            if (cyc <= WIDTH) begin
                checkOutput("busy", busy, 1);
                checkOutput("done_early", done, 0);
                checkOutput("stall", stall, {31'd0, req | extra});
            end else begin
                checkOutput("done_pulse", done, (flush_at == cyc) ? 0 : 1);
                checkOutput("done_busy", busy, 0);
                checkOutput("done_stall", stall, 0);
            end
            checkOutput("hi_hold", hi, exp_hi);
            checkOutput("lo_hold", lo, exp_lo);
            step();
            if (flush_at == cyc) begin
                applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                #1;
                checkOutput("flush_busy", busy, 0);
                checkOutput("flush_done", done, 0);
                checkOutput("flush_hi", hi, exp_hi);
                checkOutput("flush_lo", lo, exp_lo);
                step();
                checkOutput("flush_idle_done", done, 0);
                return;
            end
        end
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        checkOutput("post_busy", busy, 0);
        checkOutput("post_done", done, 0);
        checkOutput("post_stall", stall, 0);
        checkOutput("result_hi", hi, exp_hi);
        checkOutput("result_lo", lo, exp_lo);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rd;

        // Reset state
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_lo", lo, 0);
        step();
        reset_n = 1'b1;
        step();

        // MTHI / MTLO in IDLE
        applyStimulus(1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("mthi_stall", stall, 0);
        step();
        exp_hi = 32'hDEAD_BEEF;
        checkOutput("mthi_hi", hi, exp_hi);
        checkOutput("mthi_lo", lo, exp_lo);
        applyStimulus(1'b0, 1'b0, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        exp_lo = 32'h1234_5678;
        checkOutput("mtlo_hi", hi, exp_hi);
        checkOutput("mtlo_lo", lo, exp_lo);

        // Directed examples
        runOp(32'd7, 32'd6, 1'b0, 0, 1'b0, 0);
        checkOutput("mul7x6_lo", lo, 32'd42);
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 0);
        checkOutput("mulmax_hi", hi, 32'hFFFF_FFFE);
        runOp(32'd100, 32'd7, 1'b1, 0, 1'b0, 0);
        checkOutput("div100_7_hi", hi, 32'd2);
        runOp(32'd5, 32'd0, 1'b1, 0, 1'b0, 0);
        checkOutput("div5_0_lo", lo, 32'hFFFF_FFFF);

        // Held MFHI/MFLO from cycle 3, and start while busy
        runOp(32'd1234, 32'd5678, 1'b0, 3, 1'b0, 0);
        runOp(32'd99, 32'd3, 1'b1, 0, 1'b1, 0);

        // Flush mid-DIV, and flush in the DONE cycle
        runOp(32'd1000, 32'd9, 1'b1, 0, 1'b0, 10);
        runOp(32'd11, 32'd13, 1'b0, 0, 1'b0, WIDTH + 1);

        // Flush together with start in IDLE
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("flush_start_busy", busy, 0);

        // Start with MTHI/MTLO in the same cycle: the writes are dropped
        applyStimulus(1'b1, 1'b0, 32'hAAAA_5555, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("startwr_busy", busy, 1);
        checkOutput("startwr_hi", hi, exp_hi);
        checkOutput("startwr_lo", lo, exp_lo);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-MUL
        runOp(32'hFFFF_0001, 32'h0001_0003, 1'b0, 0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 32'd77, 32'd88, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        checkOutput("arst_stall", stall, 0);
        checkOutput("arst_hi", hi, exp_hi);
        checkOutput("arst_lo", lo, exp_lo);
        step();
        reset_n = 1'b1;
        step();
        runOp(32'd77, 32'd88, 1'b0, 0, 1'b0, 0);

        // Randomized operations
        for (int n = 0; n < 12; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            rd = 1'(n % 2);
            runOp(ra, rb, rd, (n % 3 == 0) ? int'($urandom_range(1, 32)) : 0, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound the whole run
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end

endmodule
